// File: rtl/nway_mux_pkg.sv
// Shared types and helpers for the registered N-way select stage.
package nway_mux_pkg;

  // Occupancy of the stage: nothing held, main register only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Select width for m inputs; a single input still gets a one-bit select.
  function automatic int sel_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/nway_mux.sv
// Combinational M:1 N-bit select; out-of-range selects yield zero data and err=1.
module nway_mux
  import nway_mux_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int SELW = sel_width(M)
) (
  input  logic [M*N-1:0] in_data,
  input  logic [SELW-1:0] in_sel,
  output logic [N-1:0]    sel_data,
  output logic            sel_err
);

  logic [N-1:0] lane [M];

  // Unpack the flat input bus into one slice per input.
  for (genvar gi = 0; gi < M; gi++) begin : g_lane
    assign lane[gi] = in_data[gi*N +: N];
  end

  // Pick the addressed lane; no match means the select is out of range.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < M; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_data = lane[k];
        sel_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nway_mux_stage.sv
// Registered M:1 select behind a valid/ready handshake with a two-entry skid buffer.
module nway_mux_stage
  import nway_mux_pkg::*;
#(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int SELW = sel_width(M)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M*N-1:0]  in_data,
  input  logic [SELW-1:0] in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [N-1:0]    out_data,
  output logic            out_err,
  output logic            out_valid,
  input  logic            out_ready
);

  stage_state_e state_q, state_d;
  logic [N-1:0] main_data_q, main_data_d;
  logic         main_err_q, main_err_d;
  logic [N-1:0] skid_data_q, skid_data_d;
  logic         skid_err_q, skid_err_d;
  logic         in_ready_q, in_ready_d;

  logic [N-1:0] sel_data;
  logic         sel_err;
  logic         accept;
  logic         issue;

  nway_mux #(
    .N    (N),
    .M    (M),
    .SELW (SELW)
  ) u_mux (
    .in_data  (in_data),
    .in_sel   (in_sel),
    .sel_data (sel_data),
    .sel_err  (sel_err)
  );

  // in_ready comes straight from a flop so it never sees out_ready combinationally.
  assign accept    = in_valid & in_ready_q;
  assign issue     = (state_q != ST_EMPTY) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;

  // Next-state and register-load decisions for the occupancy FSM.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end
      end
      ST_ONE: begin
        if (accept && issue) begin
          main_data_d = sel_data;
          main_err_d  = sel_err;
        end else if (accept) begin
          state_d     = ST_TWO;
          skid_data_d = sel_data;
          skid_err_d  = sel_err;
        end else if (issue) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path exists.
        if (issue) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Squash wins over everything: drop held beats and any beat accepted now,
    // leaving the last output value visible but invalid.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = main_data_q;
      main_err_d  = main_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
    end

    in_ready_d = (state_d != ST_TWO);
  end

  // State, data registers and the ready flop; reset empties the stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_nway_mux_stage.sv
// Scoreboard bench for nway_mux_stage: driver pushes expected beats, monitor pops on issue.
module tb_nway_mux_stage;

  localparam int N    = 32;
  localparam int M    = 5;
  localparam int SELW = 3;

  typedef struct packed {
    logic [N-1:0] d;
    logic         e;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [M*N-1:0]  in_data = '0;
  logic [SELW-1:0] in_sel = '0;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic [N-1:0]    out_data;
  logic            out_err;
  logic            out_valid;

  beat_t        exp_q[$];
  int           checks = 0;
  int           passes = 0;
  bit           acc_flag = 1'b0;
  bit           prev_stall = 1'b0;
  logic [N-1:0] prev_data = '0;
  logic         prev_err = 1'b0;

  nway_mux_stage #(
    .N    (N),
    .M    (M),
    .SELW (SELW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  function automatic beat_t mk(input logic [N-1:0] d, input logic e);
    beat_t b;
    b.d = d;
    b.e = e;
    return b;
  endfunction

  function automatic logic [M*N-1:0] pack5(input logic [N-1:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  // Reference select behaviour used for the random traffic.
  function automatic beat_t model(input logic [M*N-1:0] d, input logic [SELW-1:0] s);
    beat_t b;
    b.d = '0;
    b.e = 1'b1;
    if (int'(s) < M) begin
      b.d = d[int'(s)*N +: N];
      b.e = 1'b0;
    end
    return b;
  endfunction

  // One cycle of stimulus, driven 1 time unit after the rising edge.
  task automatic drive(input bit v, input logic [SELW-1:0] s, input logic [M*N-1:0] d,
                       input bit ordy, input bit fl, input beat_t expb);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc_flag  = v && in_ready && !fl && rst_n;
    if (acc_flag) exp_q.push_back(expb);
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, ordy, 1'b0, mk('0, 1'b0));
  endtask

  // Monitor: sample mid-cycle, check occupancy-derived handshake and issued beats.
  initial begin
    int    held;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        held = exp_q.size() - (acc_flag ? 1 : 0);
        check("out_valid", 64'(out_valid), 64'(held > 0));
        check("in_ready", 64'(in_ready), 64'(held < 2));
        if (prev_stall) begin
          check("stall_data", 64'(out_data), 64'(prev_data));
          check("stall_err", 64'(out_err), 64'(prev_err));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_issue: got data %0h err %0b required no beat", out_data, out_err);
          end else begin
            b = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(b.d));
            check("out_err", 64'(out_err), 64'(b.e));
          end
        end
        if (flush) exp_q.delete();
      end
      prev_stall = out_valid && !out_ready && !flush && rst_n;
      prev_data  = out_data;
      prev_err   = out_err;
    end
  end

  initial begin
    logic [M*N-1:0] d;
    logic [N-1:0]   stream_exp [4];
    logic [SELW-1:0] s;
    int accepted;
    int cyc;

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #9 rst_n = 1'b1;

    // Streaming with no back-pressure.
    stream_exp[0] = 32'h00000000;
    stream_exp[1] = 32'h11111111;
    stream_exp[2] = 32'h22222222;
    stream_exp[3] = 32'h33333333;
    d = pack5(32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    for (int k = 0; k < 4; k++) drive(1'b1, SELW'(k), d, 1'b1, 1'b0, mk(stream_exp[k], 1'b0));
    idle(1'b1, 2);

    // Back-pressure: two beats fill main and skid, then drain in order.
    d = pack5(32'h0000000A, 32'h0000000B, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 3'd0, d, 1'b0, 1'b0, mk(32'h0000000A, 1'b0));
    drive(1'b1, 3'd1, d, 1'b0, 1'b0, mk(32'h0000000B, 1'b0));
    idle(1'b0, 1);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_hold_a", 64'(out_data), 64'hA);
    idle(1'b0, 2);
    idle(1'b1, 1);
    idle(1'b1, 1);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    check("bp_then_b", 64'(out_data), 64'hB);
    idle(1'b1, 2);

    // Out-of-range selects produce zero with err, in-range clears err.
    d = pack5(32'h5A5A5A5A, 32'hC0FFEE01, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF);
    drive(1'b1, 3'd5, d, 1'b1, 1'b0, mk(32'h0, 1'b1));
    drive(1'b1, 3'd7, d, 1'b1, 1'b0, mk(32'h0, 1'b1));
    drive(1'b1, 3'd1, d, 1'b1, 1'b0, mk(32'hC0FFEE01, 1'b0));
    drive(1'b1, 3'd4, d, 1'b1, 1'b0, mk(32'hDEADBEEF, 1'b0));
    idle(1'b1, 2);

    // Flush while full with in_valid high: nothing held may ever issue.
    drive(1'b1, 3'd2, d, 1'b0, 1'b0, mk(32'h12345678, 1'b0));
    drive(1'b1, 3'd3, d, 1'b0, 1'b0, mk(32'h9ABCDEF0, 1'b0));
    idle(1'b0, 1);
    drive(1'b1, 3'd4, d, 1'b0, 1'b1, mk(32'hDEADBEEF, 1'b0));
    idle(1'b0, 1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_stale_data", 64'(out_data), 64'h12345678);
    idle(1'b1, 3);

    // Flush from empty discards the beat accepted in the same cycle.
    drive(1'b1, 3'd0, d, 1'b1, 1'b1, mk(32'h5A5A5A5A, 1'b0));
    idle(1'b1, 1);
    check("flush_accept_dropped", 64'(out_valid), 64'd0);
    // An issue in the flush cycle still completes.
    drive(1'b1, 3'd1, d, 1'b1, 1'b0, mk(32'hC0FFEE01, 1'b0));
    drive(1'b0, 3'd0, d, 1'b1, 1'b1, mk(32'h0, 1'b0));
    idle(1'b1, 2);

    // Asynchronous reset while full.
    drive(1'b1, 3'd2, d, 1'b0, 1'b0, mk(32'h12345678, 1'b0));
    drive(1'b1, 3'd3, d, 1'b0, 1'b0, mk(32'h9ABCDEF0, 1'b0));
    idle(1'b0, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_out_err", 64'(out_err), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1'b1, 2);

    // Random valid/ready traffic with occasional squash.
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      for (int k = 0; k < M; k++) d[k*N +: N] = $urandom();
      s = SELW'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, s, d, $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) == 0, model(d, s));
      if (acc_flag) accepted++;
      cyc++;
    end
    check("random_beats", 64'(accepted), 64'd10000);

    // Drain whatever is left.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1'b1, 1);
    end
    idle(1'b1, 1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
